// File: rtl/rv_pkg.sv
// Shared fetch-side types and constants for the single-cycle RISC-V core.
// Holds the fetch FSM encoding and the {pc, instr} entry bundle.
package rv_pkg;

    localparam int          XLEN        = 32;
    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h00000013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {pc, instr} FIFO between fetch and decode.
// Ports: clk/reset, push/push_data, pop, flush (wins over push/pop), count, head.
module fetch_buffer
    import rv_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t head_q, head_d;
    fetch_entry_t tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         pop_ok;
    logic         push_ok;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pop_ok  = pop && (count_q != 2'd0);
        // A push into a full buffer is only legal when the head leaves now.
        push_ok = push && ((count_q != 2'd2) || pop_ok);
        if (flush) begin
            // Entries keep their data so the head output holds its last value.
            count_d = 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) head_d = push_data;
                    else                 tail_d = push_data;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) head_d = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = push_data;
                    end else begin
                        head_d = push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory, feeds the decoder.
// Ports: clk/reset, imem_addr/imem_rdata, redirect_*, halt_req, dec_*, halted, misalign_err.
module instr_fetch_unit
    import rv_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int          BUF_DEPTH  = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt_req,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_instr,
    output logic            halted,
    output logic            misalign_err
);

    localparam logic [XLEN-1:0] LAST_PC = 32'(IMEM_DEPTH - INSTR_BYTES);
    localparam logic [1:0]      FULL    = 2'(BUF_DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] pc_next;
    logic            push, pop, flush;
    logic [1:0]      count;
    fetch_entry_t    head;
    fetch_entry_t    push_data;

    assign pop       = dec_valid & dec_ready;
    assign pc_next   = pc_q + 32'(INSTR_BYTES);
    assign push_data = '{pc: pc_q, instr: imem_rdata};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        push       = 1'b0;
        flush      = 1'b0;
        if (state_q == HALT) begin
            // Only reset leaves HALT; the buffer keeps draining.
        end else if (redirect_valid) begin
            flush = 1'b1;
            if (halt_req && (state_q == RUN)) begin
                state_d = HALT;
            end else if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
                state_d    = HALT;
            end else if (redirect_pc > LAST_PC) begin
                state_d = HALT;
            end else begin
                pc_d    = redirect_pc;
                state_d = RUN;
            end
        end else if (state_q == BOOT) begin
            state_d = RUN;
        end else if (halt_req) begin
            state_d = HALT;
        end else if ((count < FULL) || pop) begin
            push = 1'b1;
            pc_d = pc_next;
            // The word at LAST_PC is still pushed; stop right after it.
            if (pc_next > LAST_PC) state_d = HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_buffer u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .count     (count),
        .head      (head)
    );

    assign imem_addr    = pc_q;
    assign dec_valid    = (count != 2'd0);
    assign dec_pc       = head.pc;
    assign dec_instr    = head.instr;
    assign halted       = (state_q == HALT);
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
// Scoreboard of expected {pc, instr} pairs popped on each decoder handshake.
module tb_instr_fetch_unit;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt_req = 1'b0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic        halted;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    fetch_entry_t exp_q[$];
    fetch_entry_t mon_e;

    logic [31:0] mem [16] = '{
        32'h00000093, 32'h019806B3, 32'h00100113, 32'h00208193,
        32'h40110233, 32'h0041F2B3, 32'h00512023, 32'h00012303,
        32'h0062A3B3, 32'hFE000EE3, 32'h00738463, 32'h00948663,
        32'h00C000EF, 32'h00008067, 32'h0000006F, 32'h00000013
    };

    always #5 clk = ~clk;

    assign imem_rdata = (imem_addr < 32'd64) ? mem[imem_addr[5:2]] : NOP_INSTR;

    instr_fetch_unit #(
        .IMEM_DEPTH (64),
        .RESET_PC   (32'd0),
        .BUF_DEPTH  (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_instr      (dec_instr),
        .halted         (halted),
        .misalign_err   (misalign_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int from_pc);
        for (int p = from_pc; p <= 60; p += 4)
            exp_q.push_back('{pc: 32'(p), instr: mem[p/4]});
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        halt_req       = 1'b0;
        exp_q.delete();
        tick(2);
        check("rst_valid", {31'd0, dec_valid}, 32'd0);
        check("rst_pc", imem_addr, 32'd0);
        check("rst_dec_pc", dec_pc, 32'd0);
        check("rst_dec_instr", dec_instr, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (halted && !dec_valid) break;
            tick(1);
        end
        check("drain_done", {31'd0, halted && !dec_valid}, 32'd1);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // A pop that coincides with an honoured redirect is discarded by the DUT.
    always @(negedge clk) begin
        if (!reset && dec_valid && dec_ready && !(redirect_valid && !halted)) begin
            check("sb_pop_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("sb_pc", dec_pc, mon_e.pc);
                check("sb_instr", dec_instr, mon_e.instr);
            end
        end
    end

    initial begin
        // Straight-line run to end of memory.
        dec_ready = 1'b1;
        do_reset();
        push_exp(0);
        tick(1);
        check("boot_no_fetch_pc", imem_addr, 32'd0);
        check("boot_no_valid", {31'd0, dec_valid}, 32'd0);
        tick(1);
        check("first_valid", {31'd0, dec_valid}, 32'd1);
        check("pc4_instr_next", imem_addr, 32'd4);
        wait_drain(40);
        check("end_pc", imem_addr, 32'd64);

        // Backpressure: fetch stalls with two entries held.
        dec_ready = 1'b0;
        do_reset();
        push_exp(0);
        tick(6);
        check("bp_pc_frozen", imem_addr, 32'd8);
        check("bp_head_pc", dec_pc, 32'd0);
        check("bp_valid", {31'd0, dec_valid}, 32'd1);
        dec_ready = 1'b1;
        wait_drain(40);

        // Redirect with full buffer and pop asserted.
        dec_ready = 1'b0;
        do_reset();
        tick(4);
        dec_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd44;
        tick(1);
        redirect_valid = 1'b0;
        check("redir_flushed", {31'd0, dec_valid}, 32'd0);
        check("redir_pc", imem_addr, 32'd44);
        push_exp(44);
        tick(1);
        check("redir_head_pc", dec_pc, 32'd44);
        check("redir_head_instr", dec_instr, 32'h00948663);
        wait_drain(20);

        // Misaligned redirect halts and sets the sticky error.
        dec_ready = 1'b0;
        do_reset();
        tick(4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd18;
        tick(1);
        check("mis_err", {31'd0, misalign_err}, 32'd1);
        check("mis_halted", {31'd0, halted}, 32'd1);
        check("mis_flushed", {31'd0, dec_valid}, 32'd0);
        redirect_pc = 32'd0;
        dec_ready   = 1'b1;
        tick(1);
        redirect_valid = 1'b0;
        tick(3);
        check("mis_ignore_pc", imem_addr, 32'd8);
        check("mis_ignore_valid", {31'd0, dec_valid}, 32'd0);
        check("mis_still_halted", {31'd0, halted}, 32'd1);

        // Halt request together with redirect: halt wins, buffer flushed.
        dec_ready = 1'b0;
        do_reset();
        tick(4);
        halt_req       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd44;
        tick(1);
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        check("hr_halted", {31'd0, halted}, 32'd1);
        check("hr_flushed", {31'd0, dec_valid}, 32'd0);
        check("hr_pc_kept", imem_addr, 32'd8);
        check("hr_no_misalign", {31'd0, misalign_err}, 32'd0);

        // Aligned but out-of-range redirect halts without the error flag.
        do_reset();
        tick(4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd64;
        tick(1);
        redirect_valid = 1'b0;
        check("oor_halted", {31'd0, halted}, 32'd1);
        check("oor_no_misalign", {31'd0, misalign_err}, 32'd0);
        check("oor_pc_kept", imem_addr, 32'd8);

        // Reset mid-stream with a full buffer.
        dec_ready = 1'b0;
        do_reset();
        tick(4);
        check("mid_full_valid", {31'd0, dec_valid}, 32'd1);
        reset = 1'b1;
        tick(1);
        check("mid_rst_valid", {31'd0, dec_valid}, 32'd0);
        check("mid_rst_pc", imem_addr, 32'd0);
        check("mid_rst_dec_pc", dec_pc, 32'd0);
        reset = 1'b0;
        tick(1);
        check("mid_boot_pc", imem_addr, 32'd0);
        check("mid_boot_valid", {31'd0, dec_valid}, 32'd0);
        tick(1);
        check("mid_run_valid", {31'd0, dec_valid}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
